// File: rtl/divide_a_if.sv
// Handshake and operand/result bundle between the multi/div issue logic and divide_a.
interface divide_a_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output start, is_signed, A, B,
        input  busy, done, div_by_zero, Hi, Lo
    );

    modport slave (
        input  start, is_signed, A, B,
        output busy, done, div_by_zero, Hi, Lo
    );
endinterface

// File: rtl/divide_a.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, Lo = quotient, Hi = remainder.
module divide_a #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clock,
    input  logic       n_reset,
    divide_a_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zdiv_q, zdiv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Operand magnitudes; the most negative value maps onto itself as an unsigned magnitude.
    assign a_mag = (bus.is_signed && bus.A[WIDTH-1]) ? (~bus.A) + WIDTH'(1) : bus.A;
    assign b_mag = (bus.is_signed && bus.B[WIDTH-1]) ? (~bus.B) + WIDTH'(1) : bus.B;

    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.Hi          = hi_q;
    assign bus.Lo          = lo_q;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zdiv_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zdiv_q  <= zdiv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zdiv_d  = zdiv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    cnt_d   = '0;
                    qneg_d  = bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    rneg_d  = bus.is_signed & bus.A[WIDTH-1];
                    zdiv_d  = (bus.B == '0);
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end

            CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                // With a zero divisor rem ends up as |A|, so the sign fix restores the original A.
                lo_d    = zdiv_q ? '1 : (qneg_q ? (~quo_q) + WIDTH'(1) : quo_q);
                hi_d    = rneg_q ? (~rem_q) + WIDTH'(1) : rem_q;
                dbz_d   = zdiv_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule
